attractor_scan_ctrl: RTL and testbench
======================================

ATTRACTOR_SCAN_CTRL -- requirements
Module: attractor_scan_ctrl

Interface
REQ-001 Parameter MAX_STEPS, default 32, maximum network steps per initial value before timeout (range 2..255).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  begin a full scan of initial values 0..255; sampled only in IDLE.
REQ-005 abort  input  1  terminate the scan; no result is issued for the current initial value.
REQ-006 net_load  output  1  one-cycle pulse; the network register loads net_init on that edge.
REQ-007 net_init  output  8  initial value presented to the network; equals current init_cnt.
REQ-008 net_step  output  1  one-cycle pulse; the network register advances one update on that edge.
REQ-009 net_state  input  8  current network register contents.
REQ-010 res_valid  output  1  result available; held until accepted.
REQ-011 res_ready  input  1  consumer accepts the result when high with res_valid.
REQ-012 res_init  output  8  initial value the result belongs to.
REQ-013 res_class  output  2  00 fixed point, 01 period-2 cycle, 10 timeout; 11 never driven.
REQ-014 res_steps  output  8  number of network steps taken when the result was decided.
REQ-015 fp_count, p2_count, to_count  output  9 each  per-scan tallies of each class.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when the scan of all 256 values has completed.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, STEP, CHECK, REPORT, DONE.
REQ-019 IDLE: start=1 -> LOAD; init_cnt, step_cnt and all three tallies cleared to 0 on that edge; start in any other state ignored.
REQ-020 LOAD: net_load=1 for exactly one cycle; h1<=init_cnt, h2_valid<=0, step_cnt<=0; next STEP.
REQ-021 STEP: net_step=1 for exactly one cycle; next CHECK (net_state valid with the new value in CHECK).
REQ-022 CHECK: step_cnt increments by 1; net_state==h1 -> class 00; else h2_valid and net_state==h2 -> class 01; fixed point has priority over period-2.
REQ-023 CHECK with no match and incremented step_cnt==MAX_STEPS -> class 10; no match and below limit -> h2<=h1, h1<=net_state, h2_valid<=1, next STEP.
REQ-024 On any CHECK decision: res_init, res_class, res_steps (incremented step_cnt) registered, matching tally incremented, next REPORT.
REQ-025 REPORT: res_valid=1, result fields stable, net_load=net_step=0 until res_valid&&res_ready.
REQ-026 On acceptance: init_cnt==255 -> DONE; else init_cnt+1 -> LOAD; res_valid low the following cycle.
REQ-027 DONE: done=1 for one cycle, then IDLE; tallies hold their values until the next start.
REQ-028 abort=1 in any non-IDLE state -> IDLE on the next edge, res_valid=0, no tally update that cycle; abort has priority over all other transitions; abort in IDLE ignored.
REQ-029 Tallies SHALL not wrap: fp_count+p2_count+to_count==256 at done.
REQ-030 net_load and net_step SHALL never be high in the same cycle.

Reset
REQ-031 rst=1 at a clock edge forces IDLE and zeros all registers and outputs (res_*, tallies, busy, done, net_load, net_step, net_init) regardless of state, including mid-scan and mid-REPORT.
REQ-032 rst has priority over abort and start.

Verification
REQ-033 Identity network (next=state), res_ready=1 -> 256 results class 00, res_steps=1, fp_count=256, done pulse once.
REQ-034 Complement network (next=~state) -> every result class 01, res_steps=2, p2_count=256.
REQ-035 Increment network (next=state+1), MAX_STEPS=32 -> every result class 10, res_steps=32, to_count=256.
REQ-036 res_ready low for 5 cycles on init 0x05 -> res_valid and fields unchanged throughout, no net_load/net_step pulses, next net_load only after acceptance with net_init=0x06.
REQ-037 abort asserted in STEP for init 0x10 -> IDLE next cycle, busy=0, no result for 0x10; start then restarts from net_init=0x00 with tallies 0.
REQ-038 rst asserted in REPORT -> next cycle res_valid=0, tallies 0, busy=0; start ignored while rst=1.

Source files
------------

// File: rtl/attractor_scan_ctrl.sv
// Scans every 8-bit initial value through an external network register and
// classifies each trajectory as fixed point, period-2 cycle, or timeout.
//
// state  | meaning
// IDLE   | waiting for start; tallies hold the last scan's totals
// LOAD   | net_load pulse, network takes net_init
// STEP   | net_step pulse, network advances one update
// CHECK  | compare net_state against the last two visited states
// REPORT | result held on res_* until res_ready
// DONE   | one-cycle done pulse after init 255 is accepted
module attractor_scan_ctrl #(
  parameter int unsigned MAX_STEPS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       net_load,
  output logic [7:0] net_init,
  output logic       net_step,
  input  logic [7:0] net_state,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_init,
  output logic [1:0] res_class,
  output logic [7:0] res_steps,
  output logic [8:0] fp_count,
  output logic [8:0] p2_count,
  output logic [8:0] to_count,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STEP, S_CHECK, S_REPORT, S_DONE
  } state_t;

  localparam logic [7:0] MAX_STEPS_C = 8'(MAX_STEPS);
  localparam logic [1:0] CLS_FP = 2'b00;
  localparam logic [1:0] CLS_P2 = 2'b01;
  localparam logic [1:0] CLS_TO = 2'b10;

  state_t     state_q, state_d;
  logic [7:0] init_cnt_q, init_cnt_d;
  logic [7:0] step_cnt_q, step_cnt_d;
  logic [7:0] h1_q, h1_d;
  logic [7:0] h2_q, h2_d;
  logic       h2_valid_q, h2_valid_d;
  logic [7:0] res_init_q, res_init_d;
  logic [1:0] res_class_q, res_class_d;
  logic [7:0] res_steps_q, res_steps_d;
  logic [8:0] fp_count_q, fp_count_d;
  logic [8:0] p2_count_q, p2_count_d;
  logic [8:0] to_count_q, to_count_d;
  logic       net_load_q, net_load_d;
  logic       net_step_q, net_step_d;
  logic       res_valid_q, res_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] step_inc;

  assign step_inc = step_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    step_cnt_d  = step_cnt_q;
    h1_d        = h1_q;
    h2_d        = h2_q;
    h2_valid_d  = h2_valid_q;
    res_init_d  = res_init_q;
    res_class_d = res_class_q;
    res_steps_d = res_steps_q;
    fp_count_d  = fp_count_q;
    p2_count_d  = p2_count_q;
    to_count_d  = to_count_q;

    // Abort wins over every other transition and freezes all bookkeeping.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_LOAD;
            init_cnt_d = 8'd0;
            step_cnt_d = 8'd0;
            fp_count_d = 9'd0;
            p2_count_d = 9'd0;
            to_count_d = 9'd0;
          end
        end
        S_LOAD: begin
          h1_d       = init_cnt_q;
          h2_valid_d = 1'b0;
          step_cnt_d = 8'd0;
          state_d    = S_STEP;
        end
        S_STEP: state_d = S_CHECK;
        S_CHECK: begin
          step_cnt_d  = step_inc;
          res_init_d  = init_cnt_q;
          res_steps_d = step_inc;
          if (net_state == h1_q) begin
            res_class_d = CLS_FP;
            fp_count_d  = fp_count_q + 9'd1;
            state_d     = S_REPORT;
          end else if (h2_valid_q && (net_state == h2_q)) begin
            res_class_d = CLS_P2;
            p2_count_d  = p2_count_q + 9'd1;
            state_d     = S_REPORT;
          end else if (step_inc == MAX_STEPS_C) begin
            res_class_d = CLS_TO;
            to_count_d  = to_count_q + 9'd1;
            state_d     = S_REPORT;
          end else begin
            res_init_d  = res_init_q;
            res_steps_d = res_steps_q;
            h2_d        = h1_q;
            h1_d        = net_state;
            h2_valid_d  = 1'b1;
            state_d     = S_STEP;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            if (init_cnt_q == 8'hFF) begin
              state_d = S_DONE;
            end else begin
              init_cnt_d = init_cnt_q + 8'd1;
              state_d    = S_LOAD;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they are flop outputs.
    net_load_d  = (state_d == S_LOAD);
    net_step_d  = (state_d == S_STEP);
    res_valid_d = (state_d == S_REPORT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      init_cnt_q  <= 8'd0;
      step_cnt_q  <= 8'd0;
      h1_q        <= 8'd0;
      h2_q        <= 8'd0;
      h2_valid_q  <= 1'b0;
      res_init_q  <= 8'd0;
      res_class_q <= 2'b00;
      res_steps_q <= 8'd0;
      fp_count_q  <= 9'd0;
      p2_count_q  <= 9'd0;
      to_count_q  <= 9'd0;
      net_load_q  <= 1'b0;
      net_step_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      step_cnt_q  <= step_cnt_d;
      h1_q        <= h1_d;
      h2_q        <= h2_d;
      h2_valid_q  <= h2_valid_d;
      res_init_q  <= res_init_d;
      res_class_q <= res_class_d;
      res_steps_q <= res_steps_d;
      fp_count_q  <= fp_count_d;
      p2_count_q  <= p2_count_d;
      to_count_q  <= to_count_d;
      net_load_q  <= net_load_d;
      net_step_q  <= net_step_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign net_load  = net_load_q;
  assign net_init  = init_cnt_q;
  assign net_step  = net_step_q;
  assign res_valid = res_valid_q;
  assign res_init  = res_init_q;
  assign res_class = res_class_q;
  assign res_steps = res_steps_q;
  assign fp_count  = fp_count_q;
  assign p2_count  = p2_count_q;
  assign to_count  = to_count_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_attractor_scan_ctrl.sv
// Bench for attractor_scan_ctrl: emulated network register, trajectory-level
// reference model, and a negedge monitor comparing every accepted result.
module tb_attractor_scan_ctrl;
  localparam int MAXS = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1, start = 1'b0, abort = 1'b0, res_ready = 1'b0;
  logic       net_load, net_step, res_valid, busy, done;
  logic [7:0] net_init, net_state, res_init, res_steps;
  logic [1:0] res_class;
  logic [8:0] fp_count, p2_count, to_count;

  always #5 clk = ~clk;

  attractor_scan_ctrl #(.MAX_STEPS(MAXS)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .net_load(net_load), .net_init(net_init), .net_step(net_step),
    .net_state(net_state), .res_valid(res_valid), .res_ready(res_ready),
    .res_init(res_init), .res_class(res_class), .res_steps(res_steps),
    .fp_count(fp_count), .p2_count(p2_count), .to_count(to_count),
    .busy(busy), .done(done)
  );

  int n_checks = 0, n_errors = 0;
  int mode = 0;            // 0 identity, 1 complement, 2 increment, 3 random map
  int ready_mode = 0;      // 0 always, 1 random, 2 stall on init 5, 3 never
  int stall_left = 0;
  logic [7:0] map [256];

  int exp_next = 0, n_results = 0, done_seen = 0, stall5 = 0;
  int m_fp = 0, m_p2 = 0, m_to = 0;
  bit prev_stall = 1'b0;
  logic [17:0] prev_fields = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] nf(input logic [7:0] s);
    case (mode)
      0:       nf = s;
      1:       nf = ~s;
      2:       nf = s + 8'd1;
      default: nf = map[s];
    endcase
  endfunction

  // Walk the trajectory: fixed point if the new state repeats the last one,
  // period-2 if it repeats the one before that, timeout at MAXS steps.
  task automatic model(input logic [7:0] x, output logic [1:0] cls, output logic [7:0] st);
    logic [7:0] cur, prev, nxt;
    cur = x; prev = x; cls = 2'd2; st = 8'(MAXS);
    for (int k = 1; k <= MAXS; k++) begin
      nxt = nf(cur);
      if (nxt == cur) begin cls = 2'd0; st = 8'(k); return; end
      if (k >= 2 && nxt == prev) begin cls = 2'd1; st = 8'(k); return; end
      prev = cur; cur = nxt;
    end
  endtask

  logic [7:0] net_q = 8'd0;
  assign net_state = net_q;
  always @(posedge clk) begin
    if (net_load) net_q <= net_init;
    else if (net_step) net_q <= nf(net_q);
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: res_ready = 1'b1;
      1: res_ready = 1'($urandom_range(0, 1));
      2: begin
        if (res_valid && res_init == 8'h05 && stall_left > 0) begin
          res_ready = 1'b0;
          stall_left--;
        end else res_ready = 1'b1;
      end
      default: res_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    logic [1:0] c;
    logic [7:0] s;
    chk("load_step_excl", {31'd0, net_load & net_step}, 0);
    if (net_load) chk("net_init", {24'd0, net_init}, {24'd0, 8'(exp_next)});
    if (res_valid) begin
      chk("no_pulse_in_report", {30'd0, net_load, net_step}, 0);
      if (prev_stall) chk("fields_stable", {14'd0, res_init, res_class, res_steps}, {14'd0, prev_fields});
    end
    if (res_valid && res_ready) begin
      model(8'(exp_next), c, s);
      chk("res_init", {24'd0, res_init}, {24'd0, 8'(exp_next)});
      chk("res_class", {30'd0, res_class}, {30'd0, c});
      chk("res_steps", {24'd0, res_steps}, {24'd0, s});
      if (c == 2'd0) m_fp++; else if (c == 2'd1) m_p2++; else m_to++;
      chk("tallies", {5'd0, fp_count, p2_count, to_count}, {5'd0, 9'(m_fp), 9'(m_p2), 9'(m_to)});
      exp_next++;
      n_results++;
    end
    if (res_valid && !res_ready && res_init == 8'h05) stall5++;
    if (done) done_seen++;
    prev_stall  = res_valid && !res_ready;
    prev_fields = {res_init, res_class, res_steps};
  end

  task automatic clear_model();
    exp_next = 0; n_results = 0; done_seen = 0; m_fp = 0; m_p2 = 0; m_to = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_load", {31'd0, net_load}, 1);
    chk("start_init", {24'd0, net_init}, 0);
    chk("start_tally_clr", {5'd0, fp_count, p2_count, to_count}, 0);
  endtask

  task automatic run_scan(input int md, input int rm);
    int efp, ep2, eto;
    logic [1:0] c;
    logic [7:0] s;
    mode = md; ready_mode = rm;
    clear_model();
    pulse_start();
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (done_seen > 0) break;
    end
    chk("done_seen", done_seen, 1);
    chk("n_results", n_results, 256);
    efp = 0; ep2 = 0; eto = 0;
    for (int x = 0; x < 256; x++) begin
      model(8'(x), c, s);
      if (c == 2'd0) efp++; else if (c == 2'd1) ep2++; else eto++;
    end
    chk("fp_count", {23'd0, fp_count}, efp);
    chk("p2_count", {23'd0, p2_count}, ep2);
    chk("to_count", {23'd0, to_count}, eto);
    chk("tally_sum", 32'(fp_count) + 32'(p2_count) + 32'(to_count), 256);
    repeat (3) @(negedge clk);
    chk("done_once", done_seen, 1);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("tally_hold", {23'd0, fp_count}, efp);
  endtask

  initial begin
    logic [1:0] c;
    logic [7:0] s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {27'd0, busy, done, res_valid, net_load, net_step}, 0);
    chk("rst_fields", {6'd0, net_init, res_init, res_class, res_steps}, 0);
    chk("rst_tallies", {5'd0, fp_count, p2_count, to_count}, 0);
    @(posedge clk); #1 rst = 1'b0;

    mode = 2; model(8'h00, c, s); chk("pin_inc", {22'd0, c, s}, {22'd0, 2'd2, 8'd32});
    mode = 1; model(8'h5A, c, s); chk("pin_cmp", {22'd0, c, s}, {22'd0, 2'd1, 8'd2});
    mode = 0; model(8'h33, c, s); chk("pin_id", {22'd0, c, s}, {22'd0, 2'd0, 8'd1});
    map[7] = 8'd9; map[9] = 8'd7; map[3] = 8'd4; map[4] = 8'd4;
    mode = 3; model(8'd7, c, s); chk("pin_map_p2", {22'd0, c, s}, {22'd0, 2'd1, 8'd2});
    model(8'd3, c, s); chk("pin_map_fp", {22'd0, c, s}, {22'd0, 2'd0, 8'd2});

    run_scan(0, 0); chk("identity_fp", {23'd0, fp_count}, 256);
    run_scan(1, 0); chk("complement_p2", {23'd0, p2_count}, 256);
    run_scan(2, 0); chk("increment_to", {23'd0, to_count}, 256);

    stall5 = 0; stall_left = 5;
    run_scan(0, 2); chk("stall_cycles", stall5, 5);

    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 3))
        0: map[i] = 8'(i);
        default: map[i] = 8'($urandom_range(0, 255));
      endcase
    end
    for (int i = 0; i < 8; i++) begin
      map[2*i+100] = 8'(2*i+101);
      map[2*i+101] = 8'(2*i+100);
    end
    run_scan(3, 1);

    // Abort while stepping init 0x10.
    mode = 0; ready_mode = 0; clear_model();
    pulse_start();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (net_step && net_init == 8'h10) break;
    end
    chk("abort_reach", {23'd0, net_step, net_init}, {23'd0, 1'b1, 8'h10});
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", {30'd0, busy, res_valid}, 0);
    chk("abort_results", n_results, 16);
    chk("abort_tally", {23'd0, fp_count}, 16);
    repeat (3) @(negedge clk);
    chk("abort_quiet", n_results, 16);
    run_scan(0, 0);

    // Reset while a result sits in REPORT.
    mode = 0; ready_mode = 3; clear_model();
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    chk("rst_reach_report", {31'd0, res_valid}, 1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst_rep_ctrl", {29'd0, busy, res_valid, done}, 0);
    chk("rst_rep_tally", {5'd0, fp_count, p2_count, to_count}, 0);
    chk("rst_rep_fields", {6'd0, net_init, res_init, res_class, res_steps}, 0);
    @(negedge clk);
    chk("rst_start_ignored", {30'd0, busy, net_load}, 0);
    @(posedge clk); #1 rst = 1'b0; start = 1'b0; ready_mode = 0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {31'd0, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
